// File: rtl/pdecoder_grant_seq.sv
// pdecoder_grant_seq
// Turns a {code, valid} word from the request priority encoder into a one-hot
// grant that is held for HOLD cycles. An all-zero GAP window follows every grant
// (break-before-make) before the next word is accepted. An abort ends the grant
// early. done/aborted pulse once as each grant ends, and grant_cnt counts issued
// grants, saturating at all-ones.
module pdecoder_grant_seq #(
  parameter int N_OUT  = 4,
  parameter int CODE_W = 2,
  parameter int HOLD   = 3,
  parameter int GAP    = 1,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CODE_W-1:0] in_code,
  input  logic              in_req,
  input  logic              abort,
  output logic [N_OUT-1:0]  grant,
  output logic              grant_act,
  output logic              done,
  output logic              aborted,
  output logic [CNT_W-1:0]  grant_cnt
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_GRANT = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;

  // Counters load HOLD-1 / GAP-1 and count down to zero.
  localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam int GW = (GAP  > 1) ? $clog2(GAP)  : 1;

  localparam logic [N_OUT-1:0] ONE = {{(N_OUT-1){1'b0}}, 1'b1};

  logic [1:0]       state_q,   state_d;
  logic [HW-1:0]    hold_q,    hold_d;
  logic [GW-1:0]    gap_q,     gap_d;
  logic [N_OUT-1:0] grant_q,   grant_d;
  logic             act_q,     act_d;
  logic             done_q,    done_d;
  logic             aborted_q, aborted_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;

  // The only combinational output: ready exactly while idle.
  assign in_ready  = (state_q == S_IDLE);
  assign grant     = grant_q;
  assign grant_act = act_q;
  assign done      = done_q;
  assign aborted   = aborted_q;
  assign grant_cnt = cnt_q;

  // Next-state logic.
  // The grant vector is built at accept time and then simply held.
  // A later in_code change therefore cannot disturb the active grant.
  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    gap_d     = gap_q;
    grant_d   = grant_q;
    done_d    = 1'b0;
    aborted_d = 1'b0;
    cnt_d     = cnt_q;
    case (state_q)
      S_IDLE: begin
        // A word with in_req=0 is consumed here without producing a grant.
        if (in_valid && in_req) begin
          grant_d = ONE << in_code;
          state_d = S_GRANT;
          hold_d  = HW'(HOLD - 1);
          if (cnt_q != {CNT_W{1'b1}}) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_GRANT: begin
        // An abort on the final hold cycle still reports as aborted.
        if (abort || (hold_q == '0)) begin
          grant_d   = '0;
          done_d    = 1'b1;
          aborted_d = abort;
          if (GAP > 0) begin
            state_d = S_GAP;
            gap_d   = GW'(GAP - 1);
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          hold_d = hold_q - 1'b1;
        end
      end
      S_GAP: begin
        if (gap_q == '0) begin
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
      end
    endcase
    act_d = |grant_d;
  end

  // State and output registers.
  // The asynchronous reset drops the grant at once and suppresses any done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      hold_q    <= '0;
      gap_q     <= '0;
      grant_q   <= '0;
      act_q     <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      gap_q     <= gap_d;
      grant_q   <= grant_d;
      act_q     <= act_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule
